// File: rtl/sprite_pos_ctrl_if.sv
// ---------------------------------------------------------------------------
// sprite_pos_ctrl_if
// Bundles the command inputs and position outputs of sprite_pos_ctrl.
// Signal names carry the controller's point of view (i_ = into the
// controller, o_ = out of the controller).
//   i_mode        0 = step mode, 1 = continuous mode
//   i_frame_tick  one-cycle pulse per video frame
//   i_key_ready   keypad ready level, i_key_code valid while high
//   i_key_code    5-bit keypad code
//   i_ps2_ready   PS/2 ready level, i_ps2_code valid while high
//   i_ps2_code    [7:0] scan code, [8] = 1 marks a break (release)
//   o_pos_x/y     sprite coordinates
//   o_dir         00 right, 01 left, 10 up, 11 down
//   o_moving      continuous-mode motion active
//   o_pend_valid  a decoded command waits for the next frame tick
//   o_hit_wall    one-cycle pulse when a step was clamped at a bound
// Modports: master drives commands (input decoders / bench),
//           slave is the controller.
// ---------------------------------------------------------------------------
interface sprite_pos_ctrl_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  logic           i_mode;
  logic           i_frame_tick;
  logic           i_key_ready;
  logic [4:0]     i_key_code;
  logic           i_ps2_ready;
  logic [9:0]     i_ps2_code;
  logic [X_W-1:0] o_pos_x;
  logic [Y_W-1:0] o_pos_y;
  logic [1:0]     o_dir;
  logic           o_moving;
  logic           o_pend_valid;
  logic           o_hit_wall;

  modport master (
    output i_mode, i_frame_tick, i_key_ready, i_key_code, i_ps2_ready, i_ps2_code,
    input  o_pos_x, o_pos_y, o_dir, o_moving, o_pend_valid, o_hit_wall
  );

  modport slave (
    input  i_mode, i_frame_tick, i_key_ready, i_key_code, i_ps2_ready, i_ps2_code,
    output o_pos_x, o_pos_y, o_dir, o_moving, o_pend_valid, o_hit_wall
  );
endinterface

// File: rtl/sprite_pos_ctrl.sv
// ---------------------------------------------------------------------------
// sprite_pos_ctrl
// Position controller for one game sprite. Keypad and PS/2 direction
// commands are edge-captured into a one-deep pending register and applied
// on the next frame tick, either as a single step (step mode) or as
// persistent motion (continuous mode). Coordinates are kept inside
// [X_MIN, X_MAX] x [Y_MIN, Y_MAX].
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    sprite_pos_ctrl_if.slave (commands in, position/status out)
// Build option:
//   SPRITE_WRAP_EN  when defined, leaving a bound wraps to the opposite
//                   bound (tunnel); hit_wall never pulses and motion is
//                   not stopped. Undefined: clamp at the bound.
// ---------------------------------------------------------------------------
module sprite_pos_ctrl #(
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int STEP   = 20,
  parameter int X_MIN  = 0,
  parameter int X_MAX  = 608,
  parameter int Y_MIN  = 0,
  parameter int Y_MAX  = 448,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
) (
  input logic                clk,
  input logic                rst_n,
  sprite_pos_ctrl_if.slave   bus
);

`ifdef SPRITE_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  // Arithmetic is one bit wider than the coordinate so nothing wraps silently.
  localparam logic [X_W:0]   X_STEP_E = (X_W+1)'(STEP);
  localparam logic [X_W:0]   X_MAX_E  = (X_W+1)'(X_MAX);
  // A decreasing step falls below MIN exactly when pos < STEP + MIN;
  // testing this before subtracting avoids a borrow into the extra bit.
  localparam logic [X_W:0]   X_LO_LIM = (X_W+1)'(STEP + X_MIN);
  localparam logic [X_W-1:0] X_MIN_V  = X_W'(X_MIN);
  localparam logic [X_W-1:0] X_MAX_V  = X_W'(X_MAX);
  localparam logic [X_W-1:0] X_INIT_V = X_W'(X_INIT);

  localparam logic [Y_W:0]   Y_STEP_E = (Y_W+1)'(STEP);
  localparam logic [Y_W:0]   Y_MAX_E  = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0]   Y_LO_LIM = (Y_W+1)'(STEP + Y_MIN);
  localparam logic [Y_W-1:0] Y_MIN_V  = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0] Y_MAX_V  = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0] Y_INIT_V = Y_W'(Y_INIT);

  // Decoded command format: {valid, stop, dir[1:0]}
  function automatic logic [3:0] key_decode(input logic [4:0] code);
    logic [3:0] res;
    case (code)
      5'h0C:   res = {1'b1, 1'b0, DIR_LEFT};
      5'h0E:   res = {1'b1, 1'b0, DIR_RIGHT};
      5'h09:   res = {1'b1, 1'b0, DIR_UP};
      5'h11:   res = {1'b1, 1'b0, DIR_DOWN};
      5'h10:   res = {1'b1, 1'b1, DIR_RIGHT};
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] ps2_decode(input logic [8:0] code);
    logic [3:0] res;
    if (code[8]) begin
      res = 4'b0000;   // break codes never command motion
    end else begin
      case (code[7:0])
        8'h6B:   res = {1'b1, 1'b0, DIR_LEFT};
        8'h74:   res = {1'b1, 1'b0, DIR_RIGHT};
        8'h75:   res = {1'b1, 1'b0, DIR_UP};
        8'h72:   res = {1'b1, 1'b0, DIR_DOWN};
        8'h29:   res = {1'b1, 1'b1, DIR_RIGHT};
        default: res = 4'b0000;
      endcase
    end
    return res;
  endfunction

  logic           r_key_prev, r_ps2_prev;
  logic           r_pend_valid, r_pend_stop;
  logic [1:0]     r_pend_dir;
  logic [X_W-1:0] r_pos_x;
  logic [Y_W-1:0] r_pos_y;
  logic [1:0]     r_dir;
  logic           r_moving, r_hit_wall;

  logic [3:0]     w_key_dec, w_ps2_dec;
  logic           w_new_valid, w_new_stop;
  logic [1:0]     w_new_dir;
  logic [1:0]     w_nx_dir;
  logic           w_nx_moving, w_do_step;
  logic [X_W:0]   w_x_ext, w_x_calc;
  logic [Y_W:0]   w_y_ext, w_y_calc;
  logic           w_x_lo, w_x_hi, w_y_lo, w_y_hi;
  logic [X_W-1:0] w_nx_pos_x;
  logic [Y_W-1:0] w_nx_pos_y;
  logic           w_clamp;
  logic           w_unused;

  assign w_unused  = bus.i_ps2_code[9];
  assign w_key_dec = key_decode(bus.i_key_code);
  assign w_ps2_dec = ps2_decode(bus.i_ps2_code[8:0]);

  // Command capture on ready rising edges; keypad has priority over PS/2.
  always_comb begin
    w_new_valid = 1'b0;
    w_new_stop  = 1'b0;
    w_new_dir   = DIR_RIGHT;
    if (bus.i_key_ready && !r_key_prev && w_key_dec[3]) begin
      w_new_valid = 1'b1;
      w_new_stop  = w_key_dec[2];
      w_new_dir   = w_key_dec[1:0];
    end else if (bus.i_ps2_ready && !r_ps2_prev && w_ps2_dec[3]) begin
      w_new_valid = 1'b1;
      w_new_stop  = w_ps2_dec[2];
      w_new_dir   = w_ps2_dec[1:0];
    end else begin
      w_new_valid = 1'b0;
    end
  end

  // Direction / motion decision for a frame tick, from the pending command.
  always_comb begin
    w_nx_dir    = r_dir;
    w_nx_moving = r_moving;
    w_do_step   = 1'b0;
    if (bus.i_mode) begin
      if (r_pend_valid && r_pend_stop) begin
        w_nx_moving = 1'b0;
      end else if (r_pend_valid) begin
        w_nx_moving = 1'b1;
        w_nx_dir    = r_pend_dir;
      end else begin
        w_nx_moving = r_moving;
      end
      w_do_step = w_nx_moving;
    end else begin
      // Step mode never keeps motion alive, so leaving continuous mode stops here.
      w_nx_moving = 1'b0;
      if (r_pend_valid && !r_pend_stop) begin
        w_nx_dir  = r_pend_dir;
        w_do_step = 1'b1;
      end else begin
        w_do_step = 1'b0;
      end
    end
  end

  // One STEP along the chosen axis, with out-of-range detection.
  always_comb begin
    w_x_ext  = {1'b0, r_pos_x};
    w_y_ext  = {1'b0, r_pos_y};
    w_x_calc = w_x_ext;
    w_y_calc = w_y_ext;
    w_x_lo   = 1'b0;
    w_x_hi   = 1'b0;
    w_y_lo   = 1'b0;
    w_y_hi   = 1'b0;
    if (w_do_step) begin
      case (w_nx_dir)
        DIR_RIGHT: begin
          w_x_calc = w_x_ext + X_STEP_E;
          w_x_hi   = (w_x_calc > X_MAX_E);
        end
        DIR_LEFT: begin
          w_x_calc = w_x_ext - X_STEP_E;
          w_x_lo   = (w_x_ext < X_LO_LIM);
        end
        DIR_UP: begin
          w_y_calc = w_y_ext - Y_STEP_E;
          w_y_lo   = (w_y_ext < Y_LO_LIM);
        end
        DIR_DOWN: begin
          w_y_calc = w_y_ext + Y_STEP_E;
          w_y_hi   = (w_y_calc > Y_MAX_E);
        end
        default: begin
          w_x_calc = w_x_ext;
        end
      endcase
    end else begin
      w_x_calc = w_x_ext;
    end
  end

  // Resolve out-of-range results: clamp to the bound, or wrap to the opposite one.
  always_comb begin
    w_nx_pos_x = w_x_calc[X_W-1:0];
    w_nx_pos_y = w_y_calc[Y_W-1:0];
    if (w_x_lo) begin
      w_nx_pos_x = WRAP_EN ? X_MAX_V : X_MIN_V;
    end else if (w_x_hi) begin
      w_nx_pos_x = WRAP_EN ? X_MIN_V : X_MAX_V;
    end else begin
      w_nx_pos_x = w_x_calc[X_W-1:0];
    end
    if (w_y_lo) begin
      w_nx_pos_y = WRAP_EN ? Y_MAX_V : Y_MIN_V;
    end else if (w_y_hi) begin
      w_nx_pos_y = WRAP_EN ? Y_MIN_V : Y_MAX_V;
    end else begin
      w_nx_pos_y = w_y_calc[Y_W-1:0];
    end
    w_clamp = !WRAP_EN && (w_x_lo || w_x_hi || w_y_lo || w_y_hi);
  end

  // Ready-edge history and the one-deep pending command register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_prev   <= 1'b0;
      r_ps2_prev   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_stop  <= 1'b0;
      r_pend_dir   <= DIR_RIGHT;
    end else begin
      r_key_prev <= bus.i_key_ready;
      r_ps2_prev <= bus.i_ps2_ready;
      // A command arriving with the tick is kept for the following tick.
      if (w_new_valid) begin
        r_pend_valid <= 1'b1;
        r_pend_stop  <= w_new_stop;
        r_pend_dir   <= w_new_dir;
      end else if (bus.i_frame_tick) begin
        r_pend_valid <= 1'b0;
      end else begin
        r_pend_valid <= r_pend_valid;
      end
    end
  end

  // Position, direction and motion state, updated only on frame ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos_x    <= X_INIT_V;
      r_pos_y    <= Y_INIT_V;
      r_dir      <= DIR_RIGHT;
      r_moving   <= 1'b0;
      r_hit_wall <= 1'b0;
    end else if (bus.i_frame_tick) begin
      r_pos_x    <= w_nx_pos_x;
      r_pos_y    <= w_nx_pos_y;
      r_dir      <= w_nx_dir;
      r_moving   <= w_nx_moving && !w_clamp;
      r_hit_wall <= w_clamp;
    end else begin
      r_hit_wall <= 1'b0;
    end
  end

  assign bus.o_pos_x      = r_pos_x;
  assign bus.o_pos_y      = r_pos_y;
  assign bus.o_dir        = r_dir;
  assign bus.o_moving     = r_moving;
  assign bus.o_pend_valid = r_pend_valid;
  assign bus.o_hit_wall   = r_hit_wall;

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sprite_pos_ctrl
// Drives sprite_pos_ctrl through a directed scenario followed by random
// command/tick traffic and compares every output each cycle against a
// behavioural model computed with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_sprite_pos_ctrl;
  localparam int X_W = 10, Y_W = 9, STEP = 20;
  localparam int X_MIN = 0, X_MAX = 608, Y_MIN = 0, Y_MAX = 448;
  localparam int X_INIT = 320, Y_INIT = 240;
`ifdef SPRITE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sprite_pos_ctrl_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

  sprite_pos_ctrl #(
    .X_W(X_W), .Y_W(Y_W), .STEP(STEP),
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
    .X_INIT(X_INIT), .Y_INIT(Y_INIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state: pending is -1 (none), 0..3 direction, 4 stop.
  int m_x, m_y, m_dir, m_pend;
  bit m_moving, m_hit, m_kprev, m_pprev;

  function automatic int key_dec(input logic [4:0] c);
    if (c == 5'h0E) return 0;
    if (c == 5'h0C) return 1;
    if (c == 5'h09) return 2;
    if (c == 5'h11) return 3;
    if (c == 5'h10) return 4;
    return -1;
  endfunction

  function automatic int ps2_dec(input logic [9:0] c);
    if (c[8]) return -1;
    if (c[7:0] == 8'h74) return 0;
    if (c[7:0] == 8'h6B) return 1;
    if (c[7:0] == 8'h75) return 2;
    if (c[7:0] == 8'h72) return 3;
    if (c[7:0] == 8'h29) return 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_x = X_INIT; m_y = Y_INIT; m_dir = 0; m_pend = -1;
    m_moving = 1'b0; m_hit = 1'b0; m_kprev = 1'b0; m_pprev = 1'b0;
  endtask

  task automatic model_move();
    int nx, ny;
    bit out;
    nx = m_x; ny = m_y; out = 1'b0;
    case (m_dir)
      0: nx = m_x + STEP;
      1: nx = m_x - STEP;
      2: ny = m_y - STEP;
      default: ny = m_y + STEP;
    endcase
    if (nx < X_MIN) begin nx = WRAP ? X_MAX : X_MIN; out = 1'b1; end
    if (nx > X_MAX) begin nx = WRAP ? X_MIN : X_MAX; out = 1'b1; end
    if (ny < Y_MIN) begin ny = WRAP ? Y_MAX : Y_MIN; out = 1'b1; end
    if (ny > Y_MAX) begin ny = WRAP ? Y_MIN : Y_MAX; out = 1'b1; end
    m_x = nx; m_y = ny;
    if (out && !WRAP) begin
      m_hit = 1'b1;
      m_moving = 1'b0;
    end
  endtask

  task automatic model_clock(input bit mode, input bit tick, input bit kr,
                             input logic [4:0] kc, input bit pr, input logic [9:0] pc);
    int cmd;
    cmd = -1;
    if (kr && !m_kprev && key_dec(kc) >= 0) cmd = key_dec(kc);
    else if (pr && !m_pprev && ps2_dec(pc) >= 0) cmd = ps2_dec(pc);
    m_hit = 1'b0;
    if (tick) begin
      if (mode) begin
        if (m_pend == 4) m_moving = 1'b0;
        else if (m_pend >= 0) begin m_moving = 1'b1; m_dir = m_pend; end
        if (m_moving) model_move();
      end else begin
        m_moving = 1'b0;
        if (m_pend >= 0 && m_pend < 4) begin m_dir = m_pend; model_move(); end
      end
    end
    if (cmd >= 0) m_pend = cmd;
    else if (tick) m_pend = -1;
    m_kprev = kr; m_pprev = pr;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("pos_x",      32'(bus.o_pos_x),      32'(m_x));
    chk("pos_y",      32'(bus.o_pos_y),      32'(m_y));
    chk("dir",        32'(bus.o_dir),        32'(m_dir));
    chk("moving",     32'(bus.o_moving),     32'(m_moving));
    chk("pend_valid", 32'(bus.o_pend_valid), 32'(m_pend >= 0));
    chk("hit_wall",   32'(bus.o_hit_wall),   32'(m_hit));
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge,
  // compare at the next falling edge.
  task automatic step(input bit mode, input bit tick, input bit kr,
                      input logic [4:0] kc, input bit pr, input logic [9:0] pc);
    bus.i_mode = mode; bus.i_frame_tick = tick;
    bus.i_key_ready = kr; bus.i_key_code = kc;
    bus.i_ps2_ready = pr; bus.i_ps2_code = pc;
    @(posedge clk);
    if (rst_n) model_clock(mode, tick, kr, kc, pr, pc);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  logic [4:0] ktab [6];
  logic [7:0] ptab [6];

  initial begin
    total = 0; bad = 0;
    ktab = '{5'h0C, 5'h0E, 5'h09, 5'h11, 5'h10, 5'h1F};
    ptab = '{8'h6B, 8'h74, 8'h75, 8'h72, 8'h29, 8'h1C};
    rst_n = 1'b0;
    bus.i_mode = 1'b0; bus.i_frame_tick = 1'b0;
    bus.i_key_ready = 1'b0; bus.i_key_code = 5'h00;
    bus.i_ps2_ready = 1'b0; bus.i_ps2_code = 10'h000;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("rst_pos_x", 32'(bus.o_pos_x), 32'd320);
    chk("rst_pos_y", 32'(bus.o_pos_y), 32'd240);
    chk("rst_dir",   32'(bus.o_dir), 32'd0);
    chk("rst_flags", {28'd0, bus.o_moving, bus.o_pend_valid, bus.o_hit_wall, 1'b0}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 10'h000);

    // Step mode: keypad right, then two ticks
    step(1'b0, 1'b0, 1'b1, 5'h0E, 1'b0, 10'h000);
    chk("pend_after_edge", 32'(bus.o_pend_valid), 32'd1);
    step(1'b0, 1'b1, 1'b1, 5'h0E, 1'b0, 10'h000);
    chk("step_right_x", 32'(bus.o_pos_x), 32'd340);
    step(1'b0, 1'b1, 1'b1, 5'h0E, 1'b0, 10'h000);
    chk("idle_tick_x", 32'(bus.o_pos_x), 32'd340);
    step(1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 10'h000);

    // Keypad up and PS/2 right on the same cycle: keypad wins
    step(1'b0, 1'b0, 1'b1, 5'h09, 1'b1, 10'h074);
    step(1'b0, 1'b1, 1'b1, 5'h09, 1'b1, 10'h074);
    chk("prio_y", 32'(bus.o_pos_y), 32'd220);
    chk("prio_x", 32'(bus.o_pos_x), 32'd340);
    chk("prio_dir", 32'(bus.o_dir), 32'd2);
    step(1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 10'h000);

    // Continuous mode: PS/2 down for three ticks, then stop
    step(1'b1, 1'b0, 1'b0, 5'h00, 1'b1, 10'h072);
    repeat (3) step(1'b1, 1'b1, 1'b0, 5'h00, 1'b1, 10'h072);
    chk("cont_y", 32'(bus.o_pos_y), 32'd280);
    chk("cont_moving", 32'(bus.o_moving), 32'd1);
    step(1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 10'h000);
    step(1'b1, 1'b0, 1'b0, 5'h00, 1'b1, 10'h029);
    step(1'b1, 1'b1, 1'b0, 5'h00, 1'b1, 10'h029);
    chk("stop_moving", 32'(bus.o_moving), 32'd0);
    chk("stop_y", 32'(bus.o_pos_y), 32'd280);
    step(1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 10'h000);

    // Break code is ignored
    step(1'b1, 1'b0, 1'b0, 5'h00, 1'b1, 10'h174);
    chk("break_pend", 32'(bus.o_pend_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 5'h00, 1'b1, 10'h174);
    step(1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 10'h000);

    // Ready held high across a code change: one capture only; run left to the wall
    step(1'b1, 1'b0, 1'b0, 5'h00, 1'b1, 10'h06B);
    step(1'b1, 1'b1, 1'b0, 5'h00, 1'b1, 10'h074);
    chk("held_pend", 32'(bus.o_pend_valid), 32'd0);
    chk("held_x", 32'(bus.o_pos_x), 32'd320);
    repeat (15) step(1'b1, 1'b1, 1'b0, 5'h00, 1'b1, 10'h074);
    chk("left_x20", 32'(bus.o_pos_x), 32'd20);
    step(1'b1, 1'b1, 1'b0, 5'h00, 1'b1, 10'h074);
    chk("exact_bound_x", 32'(bus.o_pos_x), 32'd0);
    chk("exact_bound_hit", 32'(bus.o_hit_wall), 32'd0);
    step(1'b1, 1'b1, 1'b0, 5'h00, 1'b1, 10'h074);
`ifdef SPRITE_WRAP_EN
    chk("wrap_x", 32'(bus.o_pos_x), 32'd608);
    chk("wrap_hit", 32'(bus.o_hit_wall), 32'd0);
    chk("wrap_moving", 32'(bus.o_moving), 32'd1);
`else
    chk("clamp_x", 32'(bus.o_pos_x), 32'd0);
    chk("clamp_hit", 32'(bus.o_hit_wall), 32'd1);
    chk("clamp_moving", 32'(bus.o_moving), 32'd0);
`endif
    step(1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 10'h000);
    chk("hit_one_cycle", 32'(bus.o_hit_wall), 32'd0);
    step(1'b0, 1'b1, 1'b0, 5'h00, 1'b0, 10'h000);
    chk("leave_cont_moving", 32'(bus.o_moving), 32'd0);

    // Edge together with a tick stays pending for the next tick
    step(1'b0, 1'b1, 1'b1, 5'h0E, 1'b0, 10'h000);
    chk("edge_on_tick_pend", 32'(bus.o_pend_valid), 32'd1);
    step(1'b0, 1'b1, 1'b1, 5'h0E, 1'b0, 10'h000);
    step(1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 10'h000);

    // Mid-operation reset drops the pending command
    step(1'b1, 1'b0, 1'b1, 5'h11, 1'b0, 10'h000);
    do_reset();
    chk("midrst_pend", 32'(bus.o_pend_valid), 32'd0);
    chk("midrst_x", 32'(bus.o_pos_x), 32'd320);

    // Random traffic
    begin
      bit md, kr, pr;
      logic [4:0] kc;
      logic [9:0] pc;
      md = 1'b0; kr = 1'b0; pr = 1'b0; kc = 5'h00; pc = 10'h000;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 399) == 0) begin
          do_reset();
        end else begin
          if ($urandom_range(0, 39) == 0) md = ~md;
          if ($urandom_range(0, 2) == 0) kr = ~kr;
          if ($urandom_range(0, 2) == 0) pr = ~pr;
          kc = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ktab[$urandom_range(0, 5)];
          pc = {1'b0, ($urandom_range(0, 7) == 0), ptab[$urandom_range(0, 5)]};
          if ($urandom_range(0, 9) == 0) pc = 10'($urandom);
          step(md, ($urandom_range(0, 3) == 0), kr, kc, pr, pc);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sprite_pos_ctrl.md
# sprite_pos_ctrl

Parametrised position controller for one game sprite (Pac-Man or ghost). It turns keypad and PS/2 direction commands into bounded X/Y screen coordinates. It sits between the input decoders (Keypad, PS2_keyboard) and the VGA pixel mux, and replaces ad-hoc per-sprite move logic in the top level. Two modes are supported: discrete stepping (one move per command) and continuous maze-style motion (keep moving each frame until stopped or blocked).

## Interface
Parameters:
- X_W, 10, width of pos_x
- Y_W, 9, width of pos_y
- STEP, 20, pixels moved per applied step
- X_MIN, 0, lowest legal pos_x
- X_MAX, 608, highest legal pos_x (640 − 32-px sprite)
- Y_MIN, 0, lowest legal pos_y
- Y_MAX, 448, highest legal pos_y
- X_INIT, 320, pos_x after reset
- Y_INIT, 240, pos_y after reset

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  1  0 = step mode, 1 = continuous mode; sampled every cycle
- frame_tick  in  1  one-cycle pulse per video frame; the only time position changes
- key_ready  in  1  keypad ready level
- key_code  in  5  keypad code, valid while key_ready = 1
- ps2_ready  in  1  PS/2 ready level
- ps2_code  in  10  PS/2 data; [7:0] scan code, [8] = 1 marks a release (break)
- pos_x  out  X_W  sprite X coordinate
- pos_y  out  Y_W  sprite Y coordinate
- dir  out  2  current direction: 00 right, 01 left, 10 up, 11 down
- moving  out  1  continuous-mode motion active
- pend_valid  out  1  a decoded command is waiting for frame_tick
- hit_wall  out  1  one-cycle pulse when a step was clamped at a bound

## Operation
- Each source has its own previous-ready register. A command is captured only on a 0→1 transition of that source's ready.
- Keypad decode: 0x0C left, 0x0E right, 0x09 up, 0x11 down, 0x10 stop.
- PS/2 decode: 0x6B left, 0x74 right, 0x75 up, 0x72 down, 0x29 stop. Events with ps2_code[8] = 1 are ignored.
- Undecoded codes are ignored and leave the pending register unchanged.
- Keypad and PS/2 edges in the same cycle: the keypad command wins and the PS/2 command is dropped.
- Pending register is one entry deep. A newer command overwrites an unconsumed one.
- Step mode, on frame_tick with a pending direction: dir ← pending, apply one STEP along that axis, clear pending. A pending stop is simply cleared. moving stays 0.
- Continuous mode, on frame_tick:
  - A pending direction loads dir and sets moving = 1.
  - A pending stop clears moving.
  - Then, if moving = 1, apply one STEP along dir.
- Step arithmetic is done at X_W+1 / Y_W+1 bits, so no silent wrap occurs at 0 or at 2^W.
- Clamp rule: a result below MIN or above MAX is forced to that bound and hit_wall pulses. In continuous mode a clamp also clears moving.
- A result exactly equal to a bound is legal and does not raise hit_wall.
- A mode change takes effect on the next frame_tick. Leaving continuous mode clears moving at that tick.

## Timing
- Reset values: pos_x = X_INIT, pos_y = Y_INIT, dir = 00, moving = 0, pend_valid = 0, hit_wall = 0. Both prev-ready registers also reset to 0.
- pend_valid rises one cycle after the cycle in which the ready edge is seen.
- Position, dir and moving update on the rising edge that samples frame_tick = 1. They are visible the following cycle.
- hit_wall is high for exactly that one cycle.
- A command edge in the same cycle as frame_tick is not consumed by that tick. It becomes pending for the next tick.
- Reset asserted mid-operation returns all state to reset values immediately. Any pending command is lost.

## Configuration
- SPRITE_WRAP_EN defined: leaving a bound places the sprite on the opposite bound (below X_MIN → X_MAX, above X_MAX → X_MIN, same for Y), for tunnel-style wrap. In this case hit_wall never pulses and moving is not cleared.
- Undefined: clamp behaviour as in Operation.

## Test plan
- Reset, hold frame_tick = 0 → pos = (320, 240), dir = 00, all flags 0.
- Step mode, keypad 0x0E edge, then one frame_tick → pos_x = 340. A second frame_tick with nothing pending → pos_x stays 340.
- Step mode, keypad 0x09 and PS/2 0x74 edges in the same cycle, then frame_tick → pos_y = 220, pos_x unchanged.
- Step mode, from pos_x = 10, PS/2 0x6B then frame_tick → pos_x = 0, hit_wall pulses for one cycle. With SPRITE_WRAP_EN: pos_x = 608, no pulse.
- Continuous mode, PS/2 0x72 (down) then 3 frame_ticks → pos_y = 300, moving = 1. Then PS/2 0x29 and a tick → moving = 0, pos_y stays 300.
- PS/2 0x74 with ps2_code[8] = 1, plus ready held high across two command bursts → no pending command, exactly one capture per rising edge.
